// File: rtl/uart_recv_word64_pkg.sv
// Shared UART definitions: byte FSM state encodings and framing constants.
// Used by both the 64-bit receiver and its matching transmitter.
package uart_recv_word64_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  localparam int BITS_PER_BYTE  = 8;
  localparam int BYTES_PER_WORD = 8;

endpackage

// File: rtl/uart_recv_word64_if.sv
// Serial input and word-level result signals of the 64-bit UART receiver.
// master: the receiver side; slave: the line driver / word consumer side.
interface uart_recv_word64_if;
  logic        uart_rxd;
  logic        uart_done;
  logic [63:0] uart_data;
  logic        frame_err;
  logic        timeout;

  modport master (
    input  uart_rxd,
    output uart_done, uart_data, frame_err, timeout
  );

  modport slave (
    output uart_rxd,
    input  uart_done, uart_data, frame_err, timeout
  );
endinterface

// File: rtl/uart_recv_word64_rx_byte.sv
// 8N1 byte receiver: input synchroniser, byte FSM and bit timer.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | line idle, waiting for a falling edge on rxd_s
// ST_START | half a bit into the start bit; low = real start, high = glitch
// ST_DATA  | sampling 8 data bits, LSB first, one per bit period
// ST_STOP  | waiting for the mid-stop sample; high = byte done, low = framing error
// ST_BREAK | after a framing error, waiting for the line to return high
//
// byte_valid / byte_ferr are strobes on the cycle of the stop sample so the
// word level can register its pulses one cycle after the deciding sample.
module uart_recv_word64_rx_byte
  import uart_recv_word64_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int HALF         = 434
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_ferr,
  output logic       line_idle
);

  localparam int TMR_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TMR_W-1:0] BIT_LOAD  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] HALF_LOAD = TMR_W'(HALF - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(BITS_PER_BYTE - 1);

  logic [1:0]       sync_q;
  logic             rxd_s;
  logic             rxd_d;
  logic             fall;
  logic             tick;
  rx_state_t        state;
  logic [TMR_W-1:0] bit_tmr;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_q;

  assign rxd_s = sync_q[1];
  assign fall  = rxd_d & ~rxd_s;
  assign tick  = (bit_tmr == '0);

  // Two-flop synchroniser plus one delayed copy for edge detection; idle-high reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= 2'b11;
      rxd_d  <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], uart_rxd};
      rxd_d  <= rxd_s;
    end
  end

  // Byte FSM with down-counting bit timer; sampling happens when the timer hits zero.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= ST_IDLE;
      bit_tmr <= '0;
      bit_idx <= '0;
      shift_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fall) begin
            state   <= ST_START;
            bit_tmr <= HALF_LOAD;
          end
        end
        ST_START: begin
          if (tick) begin
            if (rxd_s) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_DATA;
              bit_tmr <= BIT_LOAD;
              bit_idx <= '0;
            end
          end else begin
            bit_tmr <= bit_tmr - 1'b1;
          end
        end
        ST_DATA: begin
          if (tick) begin
            shift_q <= {rxd_s, shift_q[7:1]};
            bit_tmr <= BIT_LOAD;
            if (bit_idx == LAST_BIT) state <= ST_STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end else begin
            bit_tmr <= bit_tmr - 1'b1;
          end
        end
        ST_STOP: begin
          if (tick) state <= rxd_s ? ST_IDLE : ST_BREAK;
          else      bit_tmr <= bit_tmr - 1'b1;
        end
        ST_BREAK: begin
          if (rxd_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign byte_valid = (state == ST_STOP) && tick &&  rxd_s;
  assign byte_ferr  = (state == ST_STOP) && tick && !rxd_s;
  assign byte_data  = shift_q;
  // A start edge in this cycle means the FSM is leaving IDLE, so the line is not idle.
  assign line_idle  = (state == ST_IDLE) && !fall;

endmodule

// File: rtl/uart_recv_word64.sv
// 64-bit UART receiver: packs eight 8N1 bytes (first byte in [63:56]) into a
// word, with framing-error and inter-byte timeout handling.
module uart_recv_word64
  import uart_recv_word64_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int UART_BPS     = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  uart_recv_word64_if.master bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ / UART_BPS;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int TO_CYCLES    = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W         = $clog2(TO_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LOAD   = TO_W'(TO_CYCLES - 1);
  localparam logic [2:0]      LAST_BYTE = 3'(BYTES_PER_WORD - 1);

  logic            byte_valid;
  logic [7:0]      byte_data;
  logic            byte_ferr;
  logic            line_idle;
  logic [2:0]      byte_cnt;
  logic [63:0]     word_sr;
  logic [63:0]     next_word;
  logic [TO_W-1:0] idle_tmr;
  logic            counting;
  logic            to_hit;
  logic            done_q;
  logic [63:0]     data_q;
  logic            ferr_q;
  logic            to_q;

  uart_recv_word64_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .HALF         (HALF)
  ) u_rx_byte (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .uart_rxd   (bus.uart_rxd),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ferr  (byte_ferr),
    .line_idle  (line_idle)
  );

  assign next_word = {word_sr[55:0], byte_data};
  assign counting  = line_idle && (byte_cnt != '0);
  assign to_hit    = counting && (idle_tmr == '0);

  // Idle timer: reloads whenever not counting, counts down while a partial word sits idle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)            idle_tmr <= TO_LOAD;
    else if (!counting)        idle_tmr <= TO_LOAD;
    else if (idle_tmr != '0)   idle_tmr <= idle_tmr - 1'b1;
  end

  // Word assembly and registered single-cycle status pulses.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      word_sr  <= '0;
      byte_cnt <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      to_q   <= 1'b0;
      if (byte_valid) begin
        word_sr <= next_word;
        if (byte_cnt == LAST_BYTE) begin
          data_q   <= next_word;
          done_q   <= 1'b1;
          byte_cnt <= '0;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end else if (byte_ferr) begin
        ferr_q   <= 1'b1;
        byte_cnt <= '0;
      end else if (to_hit) begin
        to_q     <= 1'b1;
        byte_cnt <= '0;
      end
    end
  end

  assign bus.uart_done = done_q;
  assign bus.uart_data = data_q;
  assign bus.frame_err = ferr_q;
  assign bus.timeout   = to_q;

endmodule

// File: doc/uart_recv_word64.md
# uart_recv_word64

Receive side of the board's 64-bit UART link. Deserialises 8N1 serial bytes arriving on a PMOD pin and packs eight consecutive bytes into one 64-bit word. Presents that word with a single-cycle done strobe to the cipher and display datapath. It is the counterpart of the 64-bit 8-byte UART transmitter. It adds start-bit glitch rejection, framing-error detection and inter-byte timeout resynchronisation.

## Interface
- CLK_FREQ, 100_000_000, system clock frequency in Hz
- UART_BPS, 115200, baud rate
- TIMEOUT_BITS, 20, idle bit-periods inside a partial word before it is discarded
- sys_clk  input  1  system clock, all logic on rising edge
- sys_rst_n  input  1  reset, asynchronous, active-low
- uart_rxd  input  1  serial line, idle high, asynchronous to sys_clk
- uart_done  output  1  one-cycle pulse, uart_data holds a new word
- uart_data  output  64  last complete word; first received byte is in [63:56], eighth byte is in [7:0]
- frame_err  output  1  one-cycle pulse on a bad stop bit
- timeout  output  1  one-cycle pulse when a partial word is discarded

One clock (sys_clk); reset asynchronous, active-low (sys_rst_n). Both are fixed.

## Operation
- Derived constants: CLKS_PER_BIT = CLK_FREQ/UART_BPS (integer division), HALF = CLKS_PER_BIT/2.
- uart_rxd passes through a 2-FF synchroniser that resets to 1. All decisions use the synchronised value rxd_s.
- Byte FSM states:
  - IDLE: on rxd_s 1→0 go to START and clear the bit counter.
  - START: at count HALF-1, resample rxd_s. If it is 1, treat it as a glitch and return to IDLE with no flag. If it is 0, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, shifted into the byte register.
  - STOP: sample after one more CLKS_PER_BIT.
    - If 1: the byte is complete; go to IDLE.
    - If 0: pulse frame_err, discard the byte, clear byte_cnt (partial word dropped), go to BREAK.
  - BREAK: wait for rxd_s = 1, then go to IDLE.
- Word assembly: on each completed byte, shift word_sr left by 8 and insert the byte at [7:0], then increment byte_cnt (3 bits).
  - When byte_cnt is 7 and a byte completes: copy word_sr (including the new byte) to uart_data, pulse uart_done, set byte_cnt to 0.
- Timeout:
  - The idle counter runs only while the FSM is in IDLE and byte_cnt ≠ 0. It clears whenever the FSM leaves IDLE.
  - When it reaches TIMEOUT_BITS·CLKS_PER_BIT: clear byte_cnt, pulse timeout. word_sr is don't-care.
- uart_data changes only together with uart_done.
- The FSM never accepts a new start edge before the mid-stop sample.

## Timing
- Reset values: uart_done=0, uart_data=0, frame_err=0, timeout=0, FSM=IDLE, byte_cnt=0, synchroniser=1.
- Cycle numbering: t0 is the first cycle with rxd_s=0 after it was 1 in IDLE.
  - Start sample: t0+HALF.
  - Data bit i (0..7) sample: t0+HALF+(i+1)·CLKS_PER_BIT.
  - Stop sample: t0+HALF+9·CLKS_PER_BIT.
- uart_done, frame_err and timeout are registered. They assert on the cycle after the deciding sample or terminal count, for exactly 1 cycle.
- Pin to rxd_s latency is 2 cycles.
- Back-to-back bytes with zero idle time are received without loss. The FSM returns to IDLE half a bit before the next start edge.
- Reset asserted mid-byte or mid-word: everything returns to reset values immediately. No pulse is emitted for the partial data.
- Timeout terminal count and a new start edge in the same cycle: the start edge wins. The FSM goes to START, no timeout pulse, byte_cnt is kept.

## Structure
- Shared header uart_defs: FSM state encodings (IDLE, START, DATA, STOP, BREAK), the bits-per-byte constant 8, and the bytes-per-word constant 8. The transmitter uses the same header.
- Sub-module uart_rx_byte contains the synchroniser, the byte FSM and the bit timer.
  - Outputs: byte_valid, byte_data[7:0], byte_ferr, line_idle.
  - uart_recv_word64 holds word_sr, byte_cnt, the timeout counter and the output registers.

## Test plan
Bench uses CLK_FREQ=8_000_000, UART_BPS=1_000_000, so CLKS_PER_BIT=8, HALF=4.
- Send bytes 01 23 45 67 89 AB CD EF back-to-back → exactly one uart_done pulse, uart_data=64'h0123_4567_89AB_CDEF. The pulse occurs 1 cycle after the 8th stop sample.
- Send a 3-cycle low glitch on an idle line → no flags, FSM back in IDLE, a following valid word is received correctly.
- Send bytes 1–3 valid, then byte 4 with stop=0 → one frame_err pulse, no uart_done. Line returns high, then eight fresh bytes 11..88 → uart_data=64'h1122_3344_5566_7788.
- Send 5 bytes, then hold the line idle for 20 bit times → one timeout pulse, uart_data unchanged (still 0 after reset). Next eight bytes form a complete word.
- Assert sys_rst_n low during bit 4 of byte 6, then release → all outputs 0. The subsequent full word is received with byte_cnt starting at 0.
- Start edge in the exact terminal-count cycle of the timeout → no timeout pulse, and the byte is appended to the partial word.
